// File: rtl/johnson_pkg.sv
// Shared types and decode helpers for Johnson (twisted-ring) code handling.
// Helpers take the code zero-extended to MAX_WIDTH plus the live width.
package johnson_pkg;

  localparam int unsigned MAX_WIDTH     = 32;
  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned PHASES        = 2 * WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } track_state_e;

  function automatic logic [MAX_WIDTH-1:0] johnson_mask(input int unsigned width);
    logic [MAX_WIDTH-1:0] mask;
    if (width >= MAX_WIDTH) mask = '1;
    else                    mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    return mask;
  endfunction

  // A thermometer code, packed at either end, has at most one adjacent-bit change.
  function automatic logic johnson_legal(input logic [MAX_WIDTH-1:0] code,
                                         input int unsigned          width);
    logic [MAX_WIDTH-1:0] pair_mask;
    logic [MAX_WIDTH-1:0] changes;
    pair_mask = johnson_mask(width) >> 1;
    changes   = (code ^ (code >> 1)) & pair_mask;
    return ($countones(changes) <= 1) && ((code & ~johnson_mask(width)) == '0);
  endfunction

  function automatic int unsigned johnson_phase(input logic [MAX_WIDTH-1:0] code,
                                                input int unsigned          width);
    int unsigned pop;
    logic        msb;
    pop = $countones(code & johnson_mask(width));
    msb = |(code & (MAX_WIDTH'(1) << (width - 1)));
    if (msb) return 2 * width - pop;
    else     return pop;
  endfunction

endpackage

// File: rtl/johnson_decode_comb.sv
// Pure combinational legality check and phase decode of a Johnson code.
module johnson_decode_comb
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [PW-1:0]    phase
);

  always_comb begin
    legal = johnson_legal(MAX_WIDTH'(code), WIDTH);
    phase = PW'(johnson_phase(MAX_WIDTH'(code), WIDTH));
  end

endmodule

// File: rtl/johnson_decoder_checker.sv
// Johnson code decoder with legality/sequence checking, lock tracking and a
// saturating error counter. State_dbg exposes the tracker state.
module johnson_decoder_checker
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERRW       = 8,
  localparam int unsigned N_PHASES  = 2 * WIDTH,
  localparam int unsigned PW        = $clog2(N_PHASES)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    Code_in,
  // Code_in is sampled only on rising edges where Code_valid is high; there is
  // no backpressure, every qualified sample is consumed. Code_valid low is a
  // bubble: nothing changes except Seq_error, which drops to 0.
  input  logic                Code_valid,
  input  logic                Err_clr,
  output logic [PW-1:0]       Phase_out,
  output logic [N_PHASES-1:0] Phase_onehot,
  output logic                Code_legal,
  output logic                Seq_error,
  output logic                Locked,
  output logic [ERRW-1:0]     Err_count,
  output track_state_e        State_dbg
);

  localparam int unsigned RUNW = $clog2(LOCK_COUNT + 1);
  localparam logic [RUNW-1:0]     RUN_ONE    = RUNW'(1);
  localparam logic [RUNW-1:0]     RUN_TARGET = RUNW'(LOCK_COUNT);
  localparam logic [PW-1:0]       PHASE_LAST = PW'(N_PHASES - 1);
  localparam logic [N_PHASES-1:0] ONEHOT0    = N_PHASES'(1);
  localparam logic [ERRW-1:0]     ERR_MAX    = '1;
  localparam logic [ERRW-1:0]     ERR_ONE    = ERRW'(1);

  logic          dec_legal;
  logic [PW-1:0] dec_phase;
  logic [PW-1:0] phase_inc;

  track_state_e  state, state_nxt;
  logic [RUNW-1:0] run, run_nxt;
  logic [PW-1:0] exp_phase, exp_nxt;
  logic          seq_err_nxt;

  logic [PW-1:0]       phase_nxt;
  logic [N_PHASES-1:0] onehot_nxt;
  logic                legal_nxt;
  logic                seq_out_nxt;
  logic                locked_nxt;
  logic [ERRW-1:0]     err_nxt;

  johnson_decode_comb #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_decode (
    .code  (Code_in),
    .legal (dec_legal),
    .phase (dec_phase)
  );

  assign phase_inc = (dec_phase == PHASE_LAST) ? '0 : dec_phase + PW'(1);
  assign State_dbg = state;

  // Tracker state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= UNLOCKED;
      run       <= '0;
      exp_phase <= '0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      exp_phase <= exp_nxt;
    end
  end

  // Tracker next-state logic
  always_comb begin
    state_nxt   = state;
    run_nxt     = run;
    exp_nxt     = exp_phase;
    seq_err_nxt = 1'b0;
    if (Code_valid) begin
      if (dec_legal) exp_nxt = phase_inc;
      unique case (state)
        UNLOCKED: begin
          if (dec_legal) begin
            state_nxt = LOCKING;
            run_nxt   = RUN_ONE;
          end else begin
            seq_err_nxt = 1'b1;
          end
        end
        LOCKING: begin
          if (!dec_legal) begin
            state_nxt   = UNLOCKED;
            run_nxt     = '0;
            seq_err_nxt = 1'b1;
          end else if (dec_phase == exp_phase) begin
            run_nxt = run + RUN_ONE;
            if (run + RUN_ONE == RUN_TARGET) state_nxt = LOCKED;
          end else begin
            run_nxt = RUN_ONE;
          end
        end
        LOCKED: begin
          if (!dec_legal) begin
            state_nxt   = UNLOCKED;
            run_nxt     = '0;
            seq_err_nxt = 1'b1;
          end else if (dec_phase != exp_phase) begin
            state_nxt   = LOCKING;
            run_nxt     = RUN_ONE;
            seq_err_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = UNLOCKED;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // Output next values; Locked tracks the state being entered so it is visible
  // one cycle after the locking sample.
  always_comb begin
    phase_nxt   = Phase_out;
    onehot_nxt  = Phase_onehot;
    legal_nxt   = Code_legal;
    seq_out_nxt = seq_err_nxt;
    locked_nxt  = (state_nxt == LOCKED);
    err_nxt     = Err_count;
    if (Code_valid) begin
      legal_nxt = dec_legal;
      if (dec_legal) begin
        phase_nxt  = dec_phase;
        onehot_nxt = ONEHOT0 << dec_phase;
      end
    end
    if (Err_clr)                               err_nxt = seq_err_nxt ? ERR_ONE : '0;
    else if (seq_err_nxt && Err_count != ERR_MAX) err_nxt = Err_count + ERR_ONE;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Phase_out    <= '0;
      Phase_onehot <= ONEHOT0;
      Code_legal   <= 1'b0;
      Seq_error    <= 1'b0;
      Locked       <= 1'b0;
      Err_count    <= '0;
    end else begin
      Phase_out    <= phase_nxt;
      Phase_onehot <= onehot_nxt;
      Code_legal   <= legal_nxt;
      Seq_error    <= seq_out_nxt;
      Locked       <= locked_nxt;
      Err_count    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Directed bench for johnson_decoder_checker (WIDTH=4, LOCK_COUNT=4, ERRW=8).
module tb_johnson_decoder_checker;
  import johnson_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   code_in = '0;
  logic         code_valid = 1'b0;
  logic         err_clr = 1'b0;
  logic [2:0]   phase_out;
  logic [7:0]   phase_onehot;
  logic         code_legal;
  logic         seq_error;
  logic         locked;
  logic [7:0]   err_count;
  track_state_e state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  johnson_decoder_checker #(
    .WIDTH      (4),
    .LOCK_COUNT (4),
    .ERRW       (8)
  ) dut (
    .Clock        (clk),
    .Reset        (rst),
    .Code_in      (code_in),
    .Code_valid   (code_valid),
    .Err_clr      (err_clr),
    .Phase_out    (phase_out),
    .Phase_onehot (phase_onehot),
    .Code_legal   (code_legal),
    .Seq_error    (seq_error),
    .Locked       (locked),
    .Err_count    (err_count),
    .State_dbg    (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: present inputs on the falling edge, return 1ns after the rising edge.
  task automatic drive(input logic [3:0] code, input logic valid, input logic clr);
    @(negedge clk);
    code_in    = code;
    code_valid = valid;
    err_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (phase_out !== 3'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", phase_out); end
    n_checks++; if (phase_onehot !== 8'h01) begin n_fail++; $display("FAIL reset_onehot got %h want 01", phase_onehot); end
    n_checks++; if (code_legal !== 1'b0) begin n_fail++; $display("FAIL reset_legal got %b want 0", code_legal); end
    n_checks++; if (seq_error !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL reset_flags got seq=%b lock=%b want 0 0", seq_error, locked); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err_count); end
    n_checks++; if (state_dbg !== UNLOCKED) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state_dbg, UNLOCKED); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lockup();
    logic [3:0] codes [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
    logic       lk    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(codes[i], 1'b1, 1'b0);
      n_checks++; if (phase_out !== 3'(i)) begin n_fail++; $display("FAIL lockup_phase[%0d] got %0d want %0d", i, phase_out, i); end
      n_checks++; if (locked !== lk[i]) begin n_fail++; $display("FAIL lockup_locked[%0d] got %b want %b", i, locked, lk[i]); end
      n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL lockup_seq[%0d] got %b want 0", i, seq_error); end
    end
    n_checks++; if (phase_onehot !== 8'b0000_1000) begin n_fail++; $display("FAIL lockup_onehot got %b want 00001000", phase_onehot); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL lockup_err got %0d want 0", err_count); end
    n_checks++; if (code_legal !== 1'b1) begin n_fail++; $display("FAIL lockup_legal got %b want 1", code_legal); end
  endtask

  task automatic test_wrap();
    logic [3:0] codes [5] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [2:0] ph    [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [7:0] oh    [5] = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    for (int i = 0; i < 5; i++) begin
      drive(codes[i], 1'b1, 1'b0);
      n_checks++; if (phase_out !== ph[i]) begin n_fail++; $display("FAIL wrap_phase[%0d] got %0d want %0d", i, phase_out, ph[i]); end
      n_checks++; if (phase_onehot !== oh[i]) begin n_fail++; $display("FAIL wrap_onehot[%0d] got %h want %h", i, phase_onehot, oh[i]); end
      n_checks++; if (locked !== 1'b1 || seq_error !== 1'b0) begin n_fail++; $display("FAIL wrap_flags[%0d] got lock=%b seq=%b want 1 0", i, locked, seq_error); end
    end
  endtask

  task automatic test_illegal();
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0011, 1'b1, 1'b0);
    drive(4'b0111, 1'b1, 1'b0);
    drive(4'b1111, 1'b1, 1'b0);
    n_checks++; if (phase_out !== 3'd4 || locked !== 1'b1) begin n_fail++; $display("FAIL illegal_pre got phase=%0d lock=%b want 4 1", phase_out, locked); end
    drive(4'b0101, 1'b1, 1'b0);
    n_checks++; if (seq_error !== 1'b1) begin n_fail++; $display("FAIL illegal_seq got %b want 1", seq_error); end
    n_checks++; if (code_legal !== 1'b0) begin n_fail++; $display("FAIL illegal_legal got %b want 0", code_legal); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL illegal_locked got %b want 0", locked); end
    n_checks++; if (phase_out !== 3'd4 || phase_onehot !== 8'h10) begin n_fail++; $display("FAIL illegal_hold got phase=%0d oh=%h want 4 10", phase_out, phase_onehot); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL illegal_err got %0d want 1", err_count); end
    n_checks++; if (state_dbg !== UNLOCKED) begin n_fail++; $display("FAIL illegal_state got %0d want %0d", state_dbg, UNLOCKED); end
    drive(4'b0000, 1'b0, 1'b0);
    n_checks++; if (seq_error !== 1'b0 || err_count !== 8'd1) begin n_fail++; $display("FAIL illegal_pulse got seq=%b err=%0d want 0 1", seq_error, err_count); end
  endtask

  task automatic test_skip();
    logic [3:0] relock [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [3:0] tail   [3] = '{4'b1000, 4'b0000, 4'b0001};
    logic [2:0] tph    [3] = '{3'd7, 3'd0, 3'd1};
    logic       tlk    [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) drive(relock[i], 1'b1, 1'b0);
    n_checks++; if (phase_out !== 3'd4 || locked !== 1'b1) begin n_fail++; $display("FAIL skip_pre got phase=%0d lock=%b want 4 1", phase_out, locked); end
    drive(4'b1100, 1'b1, 1'b0);
    n_checks++; if (seq_error !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL skip_flags got seq=%b lock=%b want 1 0", seq_error, locked); end
    n_checks++; if (phase_out !== 3'd6) begin n_fail++; $display("FAIL skip_phase got %0d want 6", phase_out); end
    n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL skip_err got %0d want 2", err_count); end
    n_checks++; if (state_dbg !== LOCKING) begin n_fail++; $display("FAIL skip_state got %0d want %0d", state_dbg, LOCKING); end
    for (int i = 0; i < 3; i++) begin
      drive(tail[i], 1'b1, 1'b0);
      n_checks++; if (phase_out !== tph[i] || locked !== tlk[i] || seq_error !== 1'b0) begin
        n_fail++; $display("FAIL skip_relock[%0d] got phase=%0d lock=%b seq=%b want %0d %b 0", i, phase_out, locked, seq_error, tph[i], tlk[i]);
      end
    end
  endtask

  task automatic test_resync();
    drive(4'b0011, 1'b1, 1'b0);
    n_checks++; if (phase_out !== 3'd2 || locked !== 1'b1) begin n_fail++; $display("FAIL resync_pre got phase=%0d lock=%b want 2 1", phase_out, locked); end
    drive(4'b0000, 1'b1, 1'b0);
    n_checks++; if (seq_error !== 1'b1 || err_count !== 8'd3 || state_dbg !== LOCKING) begin
      n_fail++; $display("FAIL resync_repeat got seq=%b err=%0d st=%0d want 1 3 %0d", seq_error, err_count, state_dbg, LOCKING);
    end
    drive(4'b0111, 1'b1, 1'b0);
    n_checks++; if (seq_error !== 1'b0 || err_count !== 8'd3 || state_dbg !== LOCKING || phase_out !== 3'd3) begin
      n_fail++; $display("FAIL resync_noerr got seq=%b err=%0d st=%0d phase=%0d want 0 3 %0d 3", seq_error, err_count, state_dbg, phase_out, LOCKING);
    end
    drive(4'b1111, 1'b1, 1'b0);
    drive(4'b1110, 1'b1, 1'b0);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL resync_early got lock=%b want 0", locked); end
    drive(4'b1100, 1'b1, 1'b0);
    n_checks++; if (locked !== 1'b1 || phase_out !== 3'd6) begin n_fail++; $display("FAIL resync_lock got lock=%b phase=%0d want 1 6", locked, phase_out); end
  endtask

  task automatic test_gaps_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0101, 1'b0, 1'b0);
      n_checks++; if (phase_out !== 3'd6 || phase_onehot !== 8'h40 || locked !== 1'b1 || code_legal !== 1'b1 || seq_error !== 1'b0 || err_count !== 8'd3) begin
        n_fail++; $display("FAIL gap_hold[%0d] got phase=%0d oh=%h lock=%b legal=%b seq=%b err=%0d want 6 40 1 1 0 3",
                           i, phase_out, phase_onehot, locked, code_legal, seq_error, err_count);
      end
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (locked !== 1'b0 || phase_out !== 3'd0 || err_count !== 8'd0 || phase_onehot !== 8'h01 || code_legal !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got lock=%b phase=%0d err=%0d oh=%h legal=%b want 0 0 0 01 0", locked, phase_out, err_count, phase_onehot, code_legal);
    end
    n_checks++; if (state_dbg !== UNLOCKED) begin n_fail++; $display("FAIL async_reset_state got %0d want %0d", state_dbg, UNLOCKED); end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1110, 1'b1, 1'b0);
    n_checks++; if (state_dbg !== LOCKING || seq_error !== 1'b0 || phase_out !== 3'd5 || locked !== 1'b0) begin
      n_fail++; $display("FAIL post_reset got st=%0d seq=%b phase=%0d lock=%b want %0d 0 5 0", state_dbg, seq_error, phase_out, locked, LOCKING);
    end
  endtask

  task automatic test_err_counter();
    for (int i = 0; i < 300; i++) begin
      drive((i % 2 == 0) ? 4'b0101 : 4'b1011, 1'b1, 1'b0);
      if (i == 254) begin
        n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL err_reach got %0d want 255", err_count); end
      end
    end
    n_checks++; if (err_count !== 8'd255 || seq_error !== 1'b1) begin n_fail++; $display("FAIL err_saturate got err=%0d seq=%b want 255 1", err_count, seq_error); end
    drive(4'b0101, 1'b1, 1'b1);
    n_checks++; if (err_count !== 8'd1 || seq_error !== 1'b1) begin n_fail++; $display("FAIL err_clr_with_err got err=%0d seq=%b want 1 1", err_count, seq_error); end
    drive(4'b0000, 1'b0, 1'b1);
    n_checks++; if (err_count !== 8'd0 || seq_error !== 1'b0) begin n_fail++; $display("FAIL err_clr_alone got err=%0d seq=%b want 0 0", err_count, seq_error); end
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_wrap();
    test_illegal();
    test_skip();
    test_resync();
    test_gaps_reset();
    test_err_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
